// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter that shares one JK flip-flop bank among NUM_REQ requesters.
//   clock, reset (async, active-low)
//   req_valid/req_op/req_mask : per-requester command ({J,K}) and bit mask
//   freeze                    : suppresses new grants
//   req_ready                 : one-hot combinational grant
//   grant_valid/grant_id      : command held in the apply stage and its requester
//   q/q_bar                   : bank state and its complement
module jk_bank_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDW = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_mask,
  input  logic                     freeze,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     grant_valid,
  output logic [IDW-1:0]           grant_id,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         q_bar
);
  logic [IDW-1:0] ptr, g, idx;
  logic [IDW:0] sum;
  logic hit, accept;
  logic [1:0] op_r;
  logic [WIDTH-1:0] mask_r, q_next;
  // Scan offsets from farthest to nearest so the last hit is the first valid index at or after ptr.
  always_comb begin
    g = '0;
    hit = 1'b0;
    sum = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      idx = sum >= (IDW+1)'(NUM_REQ) ? IDW'(sum - (IDW+1)'(NUM_REQ)) : IDW'(sum);
      if (req_valid[idx]) begin
        g = idx;
        hit = 1'b1;
      end
    end
  end
  assign accept = hit & ~freeze & reset;
  assign req_ready = accept ? NUM_REQ'(1) << g : '0;
  assign q_next = (q & ~mask_r) | (mask_r & (op_r == 2'b10 ? {WIDTH{1'b1}} :
                                             op_r == 2'b01 ? {WIDTH{1'b0}} :
                                             op_r == 2'b11 ? ~q : q));
  assign q_bar = ~q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
      grant_valid <= 1'b0;
      grant_id <= '0;
      op_r <= '0;
      mask_r <= '0;
      q <= '0;
    end else begin
      grant_valid <= accept;
      if (accept) begin
        grant_id <= g;
        op_r <= req_op[2*g +: 2];
        mask_r <= req_mask[WIDTH*g +: WIDTH];
        ptr <= g == IDW'(NUM_REQ - 1) ? '0 : g + 1'b1;
      end
      if (grant_valid) q <= q_next;
    end
  end
endmodule
